// File: rtl/ddr5_cmd_responder_pkg.sv
// ---------------------------------------------------------------------------
// ddr5_cmd_responder_pkg
// Shared declarations for the DDR5 DRAM-side command responder:
//   cmd_t        - command encodings on the scheduler interface
//   err_t        - protocol violation codes, lowest value = highest priority
//   bank_state_t - per-bank FSM states
//   rd_tag_t     - tag carried through the CAS-latency read pipeline
// ---------------------------------------------------------------------------
package ddr5_cmd_responder_pkg;

    localparam int BG_W      = 3;
    localparam int BA_W      = 2;
    localparam int RSP_ROW_W = 16;
    localparam int RSP_COL_W = 10;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT0 = 3'd1,
        CMD_ACT1 = 3'd2,
        CMD_RD   = 3'd3,
        CMD_WR   = 3'd4,
        CMD_PRE  = 3'd5,
        CMD_RSV6 = 3'd6,
        CMD_RSV7 = 3'd7
    } cmd_t;

    typedef enum logic [3:0] {
        ERR_NONE      = 4'd0,
        ERR_ILLEGAL   = 4'd1,
        ERR_ACT_SPLIT = 4'd2,
        ERR_ACT_BUSY  = 4'd3,
        ERR_TRP       = 4'd4,
        ERR_CLOSED    = 4'd5,
        ERR_TRCD      = 4'd6,
        ERR_TRAS      = 4'd7,
        ERR_CCD       = 4'd8
    } err_t;

    typedef enum logic [2:0] {
        BS_IDLE        = 3'd0,
        BS_ACT_HALF    = 3'd1,
        BS_ACTIVATING  = 3'd2,
        BS_ACTIVE      = 3'd3,
        BS_PRECHARGING = 3'd4
    } bank_state_t;

    typedef struct packed {
        logic [BG_W-1:0]      bg;
        logic [BA_W-1:0]      ba;
        logic [RSP_ROW_W-1:0] row;
        logic [RSP_COL_W-1:0] col;
    } rd_tag_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ddr5_cmd_responder_bank_fsm.sv
// ---------------------------------------------------------------------------
// ddr5_bank_fsm
// State, open row and timing for one DRAM bank.
//   state          | meaning
//   BS_IDLE        | closed, ACT0 accepted
//   BS_ACT_HALF    | ACT0 seen, ACT1 must follow next cycle
//   BS_ACTIVATING  | ACT1 seen, waiting out tRCD
//   BS_ACTIVE      | row open, RD/WR accepted, PRE once tRAS met
//   BS_PRECHARGING | PRE seen, waiting out tRP
// Ports:
//   clock, reset      - system clock, synchronous active-high reset
//   act0_hit/act1_hit - accepted ACT0/ACT1 addressed to this bank
//   pre_hit           - accepted PRE addressed to this bank
//   row_in            - row captured on ACT0
//   row               - currently captured row
//   is_idle/is_activating/is_active/is_precharging - state decode
//   tras_met          - tRAS elapsed since ACT1 (PRE legal when ACTIVE)
// ---------------------------------------------------------------------------
module ddr5_bank_fsm
    import ddr5_cmd_responder_pkg::*;
#(
    parameter int ROW_W = 16,
    parameter int T_RCD = 39,
    parameter int T_RAS = 76,
    parameter int T_RP  = 39
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             act0_hit,
    input  logic             act1_hit,
    input  logic             pre_hit,
    input  logic [ROW_W-1:0] row_in,
    output logic [ROW_W-1:0] row,
    output logic             is_idle,
    output logic             is_activating,
    output logic             is_active,
    output logic             is_precharging,
    output logic             tras_met
);

    localparam int CNT_W = $clog2(max3(T_RCD, T_RAS, T_RP) + 1);

    // One down-counter serves both phases. Loaded with T_RAS-1 on ACT1 so
    // that in cycle c it reads T_RAS-(c-t); zero means tRAS has elapsed.
    // Loaded with T_RP-1 on PRE so the bank reaches IDLE at p+T_RP.
    localparam logic [CNT_W-1:0] RAS_LOAD = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] RCD_TC   = CNT_W'(T_RAS - T_RCD + 1);

    bank_state_t      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BS_IDLE;
            cnt   <= '0;
            row_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (act0_hit) begin
                row_q <= row_in;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - 1'b1 : cnt;
        case (state)
            BS_IDLE: begin
                if (act0_hit) begin
                    state_nxt = BS_ACT_HALF;
                end
            end
            BS_ACT_HALF: begin
                // Anything but the matching ACT1 aborts the activation.
                if (act1_hit) begin
                    state_nxt = BS_ACTIVATING;
                    cnt_nxt   = RAS_LOAD;
                end else begin
                    state_nxt = BS_IDLE;
                end
            end
            BS_ACTIVATING: begin
                if (cnt <= RCD_TC) begin
                    state_nxt = BS_ACTIVE;
                end
            end
            BS_ACTIVE: begin
                if (pre_hit) begin
                    state_nxt = BS_PRECHARGING;
                    cnt_nxt   = RP_LOAD;
                end
            end
            BS_PRECHARGING: begin
                if (cnt <= CNT_W'(1)) begin
                    state_nxt = BS_IDLE;
                end
            end
            default: begin
                state_nxt = BS_IDLE;
            end
        endcase
    end

    assign row            = row_q;
    assign is_idle        = (state == BS_IDLE);
    assign is_activating  = (state == BS_ACTIVATING);
    assign is_active      = (state == BS_ACTIVE);
    assign is_precharging = (state == BS_PRECHARGING);
    assign tras_met       = (cnt == '0);

endmodule

// File: rtl/ddr5_cmd_responder.sv
// ---------------------------------------------------------------------------
// ddr5_cmd_responder
// DRAM-side model of one DDR5 channel: tracks every bank, enforces
// tRCD/tRAS/tRP/tCCD, reports violations one cycle after the offending
// command and returns read tags T_CL cycles after each accepted RD.
// Optional build macro: DDR5_RSP_LOG_EN adds a cycle counter and a
// simulation log of accepted commands and errors.
// Ports:
//   clock, reset                 - system clock, synchronous active-high reset
//   cmd_valid, cmd               - command strobe and cmd_t encoding
//   cmd_bg, cmd_ba, cmd_addr     - target bank and row/column
//   err_valid, err_code          - registered violation pulse and err_t
//   err_bg, err_ba               - bank of the offending command
//   rd_valid, rd_bg/ba/row/col   - read-data-return pulse and its tag
//   bank_open                    - per-bank ACTIVE flag, bit bg*NUM_BA+ba
// ---------------------------------------------------------------------------
module ddr5_cmd_responder
    import ddr5_cmd_responder_pkg::*;
#(
    parameter int NUM_BG = 8,
    parameter int NUM_BA = 4,
    parameter int ROW_W  = 16,
    parameter int COL_W  = 10,
    parameter int T_RCD  = 39,
    parameter int T_RAS  = 76,
    parameter int T_RP   = 39,
    parameter int T_CL   = 40,
    parameter int T_CCD  = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cmd_valid,
    input  logic [2:0]               cmd,
    input  logic [2:0]               cmd_bg,
    input  logic [1:0]               cmd_ba,
    input  logic [ROW_W-1:0]         cmd_addr,
    output logic                     err_valid,
    output logic [3:0]               err_code,
    output logic [2:0]               err_bg,
    output logic [1:0]               err_ba,
    output logic                     rd_valid,
    output logic [2:0]               rd_bg,
    output logic [1:0]               rd_ba,
    output logic [ROW_W-1:0]         rd_row,
    output logic [COL_W-1:0]         rd_col,
    output logic [NUM_BG*NUM_BA-1:0] bank_open
);

    localparam int NB    = NUM_BG * NUM_BA;
    localparam int IDX_W = $clog2(NB);
    localparam int CCD_W = $clog2(T_CCD + 1);

    cmd_t             cmd_e;
    logic [IDX_W-1:0] sel_idx;

    logic [NB-1:0]    act0_hit, act1_hit, pre_hit;
    logic [NB-1:0]    f_idle, f_activating, f_active, f_precharging, f_tras;
    logic [ROW_W-1:0] bank_row [NB];

    // ACT0 accepted last cycle: this cycle must be ACT1 to the same bank.
    logic             pend_valid;
    logic [2:0]       pend_bg;
    logic [1:0]       pend_ba;

    logic [CCD_W-1:0] ccd_cnt;

    err_t             err_c;
    logic [2:0]       err_bg_c;
    logic [1:0]       err_ba_c;
    logic             pend_split;
    logic             accept;
    logic             rd_push;
    logic             rdwr_accept;
    rd_tag_t          new_tag;

    logic [T_CL-1:0]  pipe_vld;
    rd_tag_t          pipe_tag [T_CL];

    assign cmd_e   = cmd_t'(cmd);
    assign sel_idx = IDX_W'(int'(cmd_bg) * NUM_BA + int'(cmd_ba));

    for (genvar i = 0; i < NB; i++) begin : g_bank
        ddr5_bank_fsm #(
            .ROW_W (ROW_W),
            .T_RCD (T_RCD),
            .T_RAS (T_RAS),
            .T_RP  (T_RP)
        ) u_bank (
            .clock          (clock),
            .reset          (reset),
            .act0_hit       (act0_hit[i]),
            .act1_hit       (act1_hit[i]),
            .pre_hit        (pre_hit[i]),
            .row_in         (cmd_addr),
            .row            (bank_row[i]),
            .is_idle        (f_idle[i]),
            .is_activating  (f_activating[i]),
            .is_active      (f_active[i]),
            .is_precharging (f_precharging[i]),
            .tras_met       (f_tras[i])
        );
    end

    // Error priority encoder; the lowest err_t value wins.
    always_comb begin
        err_c      = ERR_NONE;
        err_bg_c   = cmd_bg;
        err_ba_c   = cmd_ba;
        pend_split = pend_valid &&
                     !(cmd_valid && cmd_e == CMD_ACT1 &&
                       cmd_bg == pend_bg && cmd_ba == pend_ba);
        if (cmd_valid && (cmd_e == CMD_RSV6 || cmd_e == CMD_RSV7)) begin
            err_c = ERR_ILLEGAL;
        end else if (pend_split) begin
            err_c    = ERR_ACT_SPLIT;
            err_bg_c = pend_bg;
            err_ba_c = pend_ba;
        end else if (cmd_valid) begin
            case (cmd_e)
                CMD_ACT0: begin
                    if (f_activating[sel_idx] || f_active[sel_idx]) begin
                        err_c = ERR_ACT_BUSY;
                    end else if (f_precharging[sel_idx]) begin
                        err_c = ERR_TRP;
                    end
                end
                CMD_ACT1: begin
                    // ACT1 with no ACT0 in front of it is a broken pair.
                    if (!pend_valid) begin
                        err_c = ERR_ACT_SPLIT;
                    end
                end
                CMD_RD, CMD_WR: begin
                    if (f_idle[sel_idx] || f_precharging[sel_idx]) begin
                        err_c = ERR_CLOSED;
                    end else if (f_activating[sel_idx]) begin
                        err_c = ERR_TRCD;
                    end else if (ccd_cnt != '0) begin
                        err_c = ERR_CCD;
                    end
                end
                CMD_PRE: begin
                    if (f_idle[sel_idx]) begin
                        err_c = ERR_CLOSED;
                    end else if (f_activating[sel_idx] ||
                                 (f_active[sel_idx] && !f_tras[sel_idx])) begin
                        err_c = ERR_TRAS;
                    end
                end
                default: begin
                    err_c = ERR_NONE;
                end
            endcase
        end
    end

    assign accept      = cmd_valid && (err_c == ERR_NONE) && (cmd_e != CMD_NOP);
    assign rdwr_accept = accept && (cmd_e == CMD_RD || cmd_e == CMD_WR);
    assign rd_push     = accept && (cmd_e == CMD_RD);

    always_comb begin
        act0_hit = '0;
        act1_hit = '0;
        pre_hit  = '0;
        if (accept && cmd_e == CMD_ACT0) begin
            act0_hit[sel_idx] = 1'b1;
        end
        if (accept && cmd_e == CMD_ACT1) begin
            act1_hit[sel_idx] = 1'b1;
        end
        if (accept && cmd_e == CMD_PRE) begin
            pre_hit[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        new_tag     = '0;
        new_tag.bg  = cmd_bg;
        new_tag.ba  = cmd_ba;
        new_tag.row = bank_row[sel_idx];
        new_tag.col = cmd_addr[COL_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_bg    <= '0;
            pend_ba    <= '0;
            ccd_cnt    <= '0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_bg     <= '0;
            err_ba     <= '0;
        end else begin
            pend_valid <= accept && (cmd_e == CMD_ACT0);
            pend_bg    <= cmd_bg;
            pend_ba    <= cmd_ba;
            if (rdwr_accept) begin
                ccd_cnt <= CCD_W'(T_CCD - 1);
            end else if (ccd_cnt != '0) begin
                ccd_cnt <= ccd_cnt - 1'b1;
            end
            err_valid <= (err_c != ERR_NONE);
            err_code  <= err_c;
            err_bg    <= (err_c != ERR_NONE) ? err_bg_c : 3'd0;
            err_ba    <= (err_c != ERR_NONE) ? err_ba_c : 2'd0;
        end
    end

    // CAS-latency pipeline: stage k holds reads issued k+1 cycles ago.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < T_CL; i++) begin
                pipe_tag[i] <= '0;
            end
        end else begin
            pipe_vld    <= {pipe_vld[T_CL-2:0], rd_push};
            pipe_tag[0] <= rd_push ? new_tag : '0;
            for (int i = 1; i < T_CL; i++) begin
                pipe_tag[i] <= pipe_tag[i-1];
            end
        end
    end

    assign rd_valid  = pipe_vld[T_CL-1];
    assign rd_bg     = pipe_tag[T_CL-1].bg;
    assign rd_ba     = pipe_tag[T_CL-1].ba;
    assign rd_row    = pipe_tag[T_CL-1].row;
    assign rd_col    = pipe_tag[T_CL-1].col;
    assign bank_open = f_active;

`ifdef DDR5_RSP_LOG_EN
    logic [63:0] log_cycle;

    always_ff @(posedge clock) begin
        if (reset) begin
            log_cycle <= '0;
        end else begin
            log_cycle <= log_cycle + 64'd1;
            if (accept) begin
                case (cmd_e)
                    CMD_ACT0: $display("%0d %s %0d %0d %h", log_cycle, cmd_e.name(),
                                       cmd_bg, cmd_ba, cmd_addr);
                    CMD_ACT1: $display("%0d %s %0d %0d %h", log_cycle, cmd_e.name(),
                                       cmd_bg, cmd_ba, bank_row[sel_idx]);
                    CMD_RD, CMD_WR: $display("%0d %s %0d %0d %h", log_cycle, cmd_e.name(),
                                             cmd_bg, cmd_ba, cmd_addr[COL_W-1:0]);
                    default: $display("%0d %s %0d %0d", log_cycle, cmd_e.name(),
                                      cmd_bg, cmd_ba);
                endcase
            end
            if (err_c != ERR_NONE) begin
                $display("%0d ERR %s %0d %0d", log_cycle, err_c.name(), err_bg_c, err_ba_c);
            end
        end
    end
`endif

endmodule
